// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: instruction layout,
// opcode/funct3 constants and the controller's state and mux-select encodings.
package multicycle_ctrl_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
`ifdef TINY5_CSR_EN
    ST_TRAP    = 3'd5,
    ST_CSR     = 3'd6
`else
    ST_TRAP    = 3'd5
`endif
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_JALR  = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_t;

  // Opcodes that take the ordinary EXECUTE path; SYSTEM is handled separately.
  function automatic logic is_exec_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM: is_exec_opcode = 1'b1;
      default:                                     is_exec_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_instret_counter.sv
// Retired-instruction counter: wraps modulo 2^WIDTH, asynchronous active-low reset.
module instret_counter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) count_q <= '0;
    else           count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core (fetch/decode/execute/mem/writeback).
// Optional CSR support is enabled by defining TINY5_CSR_EN.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [31:0]          ir_i,
  input  logic                 mem_ack_i,
  input  logic                 branch_taken_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic                 mem_addr_sel_o,
  output logic                 ir_we_o,
  output logic                 pc_we_o,
  output logic [1:0]           pc_sel_o,
  output logic                 alu_a_sel_o,
  output logic                 alu_b_sel_o,
  output logic                 rf_we_o,
  output logic [1:0]           wb_sel_o,
  output logic                 csr_we_o,
  output logic                 trap_o,
  output logic [2:0]           state_o,
  output logic [INSTRET_W-1:0] instret_o
);

  instruction_t ir;
  ctrl_state_t  state_q;
  logic         isLoad, isStore, isBranch, isFence, isJal, isJalr, isAuipc, isOp;
  logic         unused_ir_bits;

  assign ir       = instruction_t'(ir_i);
  assign isLoad   = (ir.opcode == OPC_LOAD);
  assign isStore  = (ir.opcode == OPC_STORE);
  assign isBranch = (ir.opcode == OPC_BRANCH);
  assign isFence  = (ir.opcode == OPC_MISC_MEM);
  assign isJal    = (ir.opcode == OPC_JAL);
  assign isJalr   = (ir.opcode == OPC_JALR);
  assign isAuipc  = (ir.opcode == OPC_AUIPC);
  assign isOp     = (ir.opcode == OPC_OP);
  assign unused_ir_bits = ^ir_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: if (mem_ack_i) state_q <= ST_DECODE;
        ST_DECODE: begin
          if (ir.opcode == OPC_SYSTEM) begin
`ifdef TINY5_CSR_EN
            state_q <= (ir.funct3 == F3_PRIV) ? ST_TRAP : ST_CSR;
`else
            state_q <= ST_TRAP;
`endif
          end else if (is_exec_opcode(ir.opcode)) begin
            state_q <= ST_EXECUTE;
          end else begin
            state_q <= ST_TRAP;
          end
        end
        ST_EXECUTE: begin
          if (isBranch || isFence)    state_q <= ST_FETCH;
          else if (isLoad || isStore) state_q <= ST_MEM;
          else                        state_q <= ST_WB;
        end
        ST_MEM: if (mem_ack_i) state_q <= isStore ? ST_FETCH : ST_WB;
        ST_WB:   state_q <= ST_FETCH;
`ifdef TINY5_CSR_EN
        ST_CSR:  state_q <= ST_FETCH;
`endif
        ST_TRAP: state_q <= ST_TRAP;
        default: state_q <= ST_TRAP;
      endcase
    end
  end

  // Gating on reset_ni makes the memory request drop the moment reset asserts.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    pc_sel_o       = PC_PLUS4;
    alu_a_sel_o    = 1'b0;
    alu_b_sel_o    = 1'b0;
    rf_we_o        = 1'b0;
    wb_sel_o       = WB_ALU;
    csr_we_o       = 1'b0;
    trap_o         = 1'b0;
    if (reset_ni) begin
      case (state_q)
        ST_FETCH: begin
          mem_req_o = 1'b1;
          ir_we_o   = mem_ack_i;
        end
        ST_EXECUTE: begin
          alu_a_sel_o = isAuipc | isJal;
          alu_b_sel_o = !(isOp | isBranch);
          if (isBranch) begin
            pc_we_o  = 1'b1;
            pc_sel_o = branch_taken_i ? PC_IMM : PC_PLUS4;
          end else if (isFence) begin
            pc_we_o  = 1'b1;
          end
        end
        ST_MEM: begin
          mem_req_o      = 1'b1;
          mem_addr_sel_o = 1'b1;
          mem_we_o       = isStore;
          pc_we_o        = isStore & mem_ack_i;
        end
        ST_WB: begin
          rf_we_o  = 1'b1;
          pc_we_o  = 1'b1;
          wb_sel_o = isLoad ? WB_LOAD : ((isJal | isJalr) ? WB_PC4 : WB_ALU);
          pc_sel_o = isJal ? PC_IMM : (isJalr ? PC_JALR : PC_PLUS4);
        end
`ifdef TINY5_CSR_EN
        ST_CSR: begin
          // Set/clear forms with a zero source must not write the CSR.
          csr_we_o = !(((ir.funct3 == F3_CSRRS) || (ir.funct3 == F3_CSRRC) ||
                        (ir.funct3 == F3_CSRRSI) || (ir.funct3 == F3_CSRRCI)) &&
                       (ir.rs1 == 5'd0));
          rf_we_o  = 1'b1;
          wb_sel_o = WB_CSR;
          pc_we_o  = 1'b1;
        end
`endif
        ST_TRAP: trap_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o = state_q;

  instret_counter #(.WIDTH(INSTRET_W)) u_instret (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (pc_we_o),
    .count_o  (instret_o)
  );

endmodule
